axis_governor_pkt: RTL and testbench

- Packet-aware successor to the per-beat AXI-Stream governor.
- Sits between a producer and a consumer. Can pause or drop input packets, mirror them to a log stream, and splice whole packets from an inject stream.
- Control inputs are applied only at packet boundaries when BOUNDARY_ALIGN=1, or per beat (legacy) when BOUNDARY_ALIGN=0.
- Provides saturating statistics counters and a lossless two-way fork for logging.

---
 rtl/axis_governor_pkt_if.sv | 25 ++
 rtl/axis_governor_pkt.sv | 205 ++++++++++++++++++++
 tb/tb_axis_governor_pkt.sv | 336 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axis_governor_pkt_if.sv
// AXI-Stream bundle shared by the input, inject, output and log ports of the
// packet governor.
interface axis_governor_pkt_if #(
    parameter int DATA_WIDTH = 64,
    parameter int DEST_WIDTH = 16,
    parameter int ID_WIDTH   = 16
);
    logic [DATA_WIDTH-1:0]   TDATA;
    logic                    TVALID;
    logic                    TREADY;
    logic [DATA_WIDTH/8-1:0] TKEEP;
    logic [DEST_WIDTH-1:0]   TDEST;
    logic [ID_WIDTH-1:0]     TID;
    logic                    TLAST;

    modport master (
        output TDATA, TVALID, TKEEP, TDEST, TID, TLAST,
        input  TREADY
    );

    modport slave (
        input  TDATA, TVALID, TKEEP, TDEST, TID, TLAST,
        output TREADY
    );
endinterface

// File: rtl/axis_governor_pkt.sv
// Packet-aware AXI-Stream governor: forwards, drops or logs input packets and
// splices whole inject packets, with zero-latency paths and saturating stats.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | between packets; source and mode chosen on the next first beat
// FWD   | input packet in flight, forwarded to out (and log if enabled)
// DRP   | input packet in flight, discarded (mirrored to log if enabled)
// INJ   | inject packet in flight, forwarded to out; input held off
module axis_governor_pkt #(
    parameter int DATA_WIDTH     = 64,
    parameter int DEST_WIDTH     = 16,
    parameter int ID_WIDTH       = 16,
    parameter int CNT_WIDTH      = 32,
    parameter bit BOUNDARY_ALIGN = 1'b1,
    parameter bit INJ_PRIORITY   = 1'b1
) (
    input  logic                 clk,
    input  logic                 rstn,
    axis_governor_pkt_if.slave   in_axis,
    axis_governor_pkt_if.slave   inj_axis,
    axis_governor_pkt_if.master  out_axis,
    axis_governor_pkt_if.master  log_axis,
    input  logic                 pause,
    input  logic                 drop,
    input  logic                 log_en,
    input  logic                 clr_cnt,
    output logic                 busy,
    output logic [CNT_WIDTH-1:0] cnt_drop_pkts,
    output logic [CNT_WIDTH-1:0] cnt_inj_pkts,
    output logic [CNT_WIDTH-1:0] cnt_log_beats
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FWD  = 2'd1,
        DRP  = 2'd2,
        INJ  = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic out_done_q, log_done_q;
    logic drop_q, log_q;

    logic pending;
    logic sel_inj;
    logic mode_drop, mode_log;
    logic pause_blk;
    logic fwd, lg;
    logic src_valid, src_ready, src_last, src_hs;
    logic out_hs, log_hs;

    logic [DATA_WIDTH-1:0]   src_tdata;
    logic [DATA_WIDTH/8-1:0] src_tkeep;
    logic [DEST_WIDTH-1:0]   src_tdest;
    logic [ID_WIDTH-1:0]     src_tid;

    // ---------------- state register ----------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (src_hs && !src_last) begin
                    if (sel_inj)        state_d = INJ;
                    else if (mode_drop) state_d = DRP;
                    else                state_d = FWD;
                end
            end
            FWD, DRP: begin
                if (src_hs && src_last) state_d = IDLE;
                else if (!BOUNDARY_ALIGN) state_d = drop ? DRP : FWD;
            end
            INJ: begin
                if (src_hs && src_last) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // ---------------- output / datapath logic ----------------
    always_comb begin
        // A partially forked first beat (one branch already taken) pins the
        // input as source and reuses the mode latched on that cycle.
        pending   = (state_q == IDLE) && (out_done_q || log_done_q);
        sel_inj   = 1'b0;
        mode_drop = drop;
        mode_log  = log_en;
        pause_blk = pause;

        case (state_q)
            IDLE: begin
                if (pending) begin
                    mode_drop = drop_q;
                    mode_log  = log_q;
                    pause_blk = BOUNDARY_ALIGN ? 1'b0 : pause;
                end else begin
                    sel_inj = inj_axis.TVALID &&
                              (INJ_PRIORITY || !(in_axis.TVALID && !pause));
                end
            end
            FWD, DRP: begin
                if (BOUNDARY_ALIGN) begin
                    mode_drop = drop_q;
                    mode_log  = log_q;
                    pause_blk = 1'b0;
                end
            end
            INJ: begin
                sel_inj = 1'b1;
            end
            default: ;
        endcase

        fwd = sel_inj ? 1'b1 : !mode_drop;
        lg  = sel_inj ? 1'b0 : mode_log;

        src_valid = sel_inj ? inj_axis.TVALID : (in_axis.TVALID && !pause_blk);
        src_last  = sel_inj ? inj_axis.TLAST  : in_axis.TLAST;
        src_tdata = sel_inj ? inj_axis.TDATA  : in_axis.TDATA;
        src_tkeep = sel_inj ? inj_axis.TKEEP  : in_axis.TKEEP;
        src_tdest = sel_inj ? inj_axis.TDEST  : in_axis.TDEST;
        src_tid   = sel_inj ? inj_axis.TID    : in_axis.TID;

        src_ready = (!fwd || out_done_q || out_axis.TREADY) &&
                    (!lg  || log_done_q || log_axis.TREADY);

        out_axis.TVALID = rstn && src_valid && fwd && !out_done_q;
        log_axis.TVALID = rstn && src_valid && lg  && !log_done_q;
        in_axis.TREADY  = rstn && !sel_inj && !pause_blk && src_ready;
        inj_axis.TREADY = rstn && sel_inj && src_ready;

        out_axis.TDATA = src_tdata;
        out_axis.TKEEP = src_tkeep;
        out_axis.TDEST = src_tdest;
        out_axis.TID   = src_tid;
        out_axis.TLAST = src_last;
        log_axis.TDATA = src_tdata;
        log_axis.TKEEP = src_tkeep;
        log_axis.TDEST = src_tdest;
        log_axis.TID   = src_tid;
        log_axis.TLAST = src_last;

        src_hs = src_valid && src_ready;
        out_hs = out_axis.TVALID && out_axis.TREADY;
        log_hs = log_axis.TVALID && log_axis.TREADY;

        busy = (state_q != IDLE);
    end

    // ---------------- fork flags and mode latch ----------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out_done_q <= 1'b0;
            log_done_q <= 1'b0;
            drop_q     <= 1'b0;
            log_q      <= 1'b0;
        end else begin
            if (src_hs) begin
                out_done_q <= 1'b0;
                log_done_q <= 1'b0;
            end else begin
                if (out_hs) out_done_q <= 1'b1;
                if (log_hs) log_done_q <= 1'b1;
            end
            if ((state_q == IDLE) && !pending) begin
                drop_q <= drop;
                log_q  <= log_en;
            end
        end
    end

    // ---------------- statistics ----------------
    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] cnt,
                                                     input logic inc);
        if (inc && (cnt != {CNT_WIDTH{1'b1}})) return cnt + CNT_WIDTH'(1);
        return cnt;
    endfunction

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_drop_pkts <= '0;
            cnt_inj_pkts  <= '0;
            cnt_log_beats <= '0;
        end else if (clr_cnt) begin
            cnt_drop_pkts <= '0;
            cnt_inj_pkts  <= '0;
            cnt_log_beats <= '0;
        end else begin
            cnt_drop_pkts <= sat_inc(cnt_drop_pkts, src_hs && src_last && !sel_inj && mode_drop);
            cnt_inj_pkts  <= sat_inc(cnt_inj_pkts,  src_hs && src_last && sel_inj);
            cnt_log_beats <= sat_inc(cnt_log_beats, log_hs);
        end
    end

endmodule

// File: tb/tb_axis_governor_pkt.sv
// Bench for axis_governor_pkt: directed boundary cases plus randomized packet
// phases checked against a packet-level stream model.
module tb_axis_governor_pkt;
    localparam int DW  = 64;
    localparam int KW  = DW / 8;
    localparam int DSW = 16;
    localparam int IW  = 16;
    localparam int CW  = 4;
    localparam int CMAX = (1 << CW) - 1;

    typedef logic [DW+KW+DSW+IW:0] beat_t;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic pause = 1'b0, drop = 1'b0, log_en = 1'b0, clr_cnt = 1'b0;
    logic busy;
    logic [CW-1:0] cnt_drop_pkts, cnt_inj_pkts, cnt_log_beats;

    int n_vec = 0;
    int n_err = 0;

    beat_t in_q[$], inj_q[$];
    beat_t got_oi[$], got_oj[$], got_lg[$];
    bit mid = 1'b0;
    bit cur_src = 1'b0;
    bit sinks_run = 1'b0;

    axis_governor_pkt_if #(.DATA_WIDTH(DW), .DEST_WIDTH(DSW), .ID_WIDTH(IW)) in_if ();
    axis_governor_pkt_if #(.DATA_WIDTH(DW), .DEST_WIDTH(DSW), .ID_WIDTH(IW)) inj_if ();
    axis_governor_pkt_if #(.DATA_WIDTH(DW), .DEST_WIDTH(DSW), .ID_WIDTH(IW)) out_if ();
    axis_governor_pkt_if #(.DATA_WIDTH(DW), .DEST_WIDTH(DSW), .ID_WIDTH(IW)) log_if ();

    axis_governor_pkt #(
        .DATA_WIDTH(DW), .DEST_WIDTH(DSW), .ID_WIDTH(IW), .CNT_WIDTH(CW),
        .BOUNDARY_ALIGN(1'b1), .INJ_PRIORITY(1'b1)
    ) dut (
        .clk(clk), .rstn(rstn),
        .in_axis(in_if.slave), .inj_axis(inj_if.slave),
        .out_axis(out_if.master), .log_axis(log_if.master),
        .pause(pause), .drop(drop), .log_en(log_en), .clr_cnt(clr_cnt),
        .busy(busy), .cnt_drop_pkts(cnt_drop_pkts),
        .cnt_inj_pkts(cnt_inj_pkts), .cnt_log_beats(cnt_log_beats)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // TID[15] marks the source: 0 = input, 1 = inject.
    function automatic beat_t mk_beat(input bit src, input bit last);
        return {$urandom, $urandom, KW'($urandom), DSW'($urandom), src, 15'($urandom), last};
    endfunction

    // Capture accepted beats; an out packet must never change source mid-packet.
    always @(negedge clk) begin
        if (rstn && out_if.TVALID && out_if.TREADY) begin
            if (mid) check_val("no_interleave", 128'(out_if.TID[15]), 128'(cur_src));
            cur_src = out_if.TID[15];
            mid = !out_if.TLAST;
            if (out_if.TID[15])
                got_oj.push_back({out_if.TDATA, out_if.TKEEP, out_if.TDEST, out_if.TID, out_if.TLAST});
            else
                got_oi.push_back({out_if.TDATA, out_if.TKEEP, out_if.TDEST, out_if.TID, out_if.TLAST});
        end
        if (rstn && log_if.TVALID && log_if.TREADY)
            got_lg.push_back({log_if.TDATA, log_if.TKEEP, log_if.TDEST, log_if.TID, log_if.TLAST});
    end

    task automatic set_src(input bit is_inj, input beat_t b, input bit v);
        if (is_inj) begin
            {inj_if.TDATA, inj_if.TKEEP, inj_if.TDEST, inj_if.TID, inj_if.TLAST} = b;
            inj_if.TVALID = v;
        end else begin
            {in_if.TDATA, in_if.TKEEP, in_if.TDEST, in_if.TID, in_if.TLAST} = b;
            in_if.TVALID = v;
        end
    endtask

    task automatic drive_src(input bit is_inj, input bit rnd);
        beat_t b;
        int t;
        while ((is_inj ? inj_q.size() : in_q.size()) > 0) begin
            if (is_inj) b = inj_q.pop_front();
            else        b = in_q.pop_front();
            if (rnd) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            set_src(is_inj, b, 1'b1);
            t = 0;
            forever begin
                @(negedge clk);
                if (is_inj ? inj_if.TREADY : in_if.TREADY) break;
                t++;
                if (t > 400) begin
                    check_val(is_inj ? "inj_timeout" : "in_timeout", 128'(t), 128'(0));
                    if (is_inj) inj_q.delete(); else in_q.delete();
                    break;
                end
                @(posedge clk); #1;
            end
            @(posedge clk); #1;
            set_src(is_inj, b, 1'b0);
        end
    endtask

    task automatic pulse_clr();
        @(posedge clk); #1 clr_cnt = 1'b1;
        @(posedge clk); #1 clr_cnt = 1'b0;
    endtask

    function automatic int sat(input int v);
        return (v > CMAX) ? CMAX : v;
    endfunction

    // One phase: fixed mode, n_in input and n_inj inject packets, then compare
    // the captured streams and counters with what the packet rules predict.
    task automatic run_phase(input int n_in, input int n_inj, input int len,
                             input bit d, input bit l, input bit rnd);
        beat_t exp_oi[$], exp_oj[$], exp_lg[$];
        beat_t b;
        int b_oi, b_oj, b_lg, plen;
        int e_drop = 0, e_inj = 0, e_log = 0;
        drop = d;
        log_en = l;
        pulse_clr();
        b_oi = got_oi.size(); b_oj = got_oj.size(); b_lg = got_lg.size();
        for (int p = 0; p < n_in; p++) begin
            plen = (len > 0) ? len : int'($urandom_range(1, 5));
            for (int k = 0; k < plen; k++) begin
                b = mk_beat(1'b0, k == plen - 1);
                in_q.push_back(b);
                if (!d) exp_oi.push_back(b);
                if (l) exp_lg.push_back(b);
            end
            if (d) e_drop++;
            if (l) e_log += plen;
        end
        for (int p = 0; p < n_inj; p++) begin
            plen = (len > 0) ? len : int'($urandom_range(1, 5));
            for (int k = 0; k < plen; k++) begin
                b = mk_beat(1'b1, k == plen - 1);
                inj_q.push_back(b);
                exp_oj.push_back(b);
            end
            e_inj++;
        end
        out_if.TREADY = 1'b1;
        log_if.TREADY = 1'b1;
        sinks_run = 1'b1;
        fork
            begin
                fork
                    drive_src(1'b0, rnd);
                    drive_src(1'b1, rnd);
                join
                sinks_run = 1'b0;
            end
            while (sinks_run) begin
                @(posedge clk); #1;
                if (rnd) begin
                    out_if.TREADY = ($urandom_range(0, 3) != 0);
                    log_if.TREADY = ($urandom_range(0, 3) != 0);
                    pause         = ($urandom_range(0, 5) == 0);
                end
            end
        join
        pause = 1'b0;
        out_if.TREADY = 1'b1;
        log_if.TREADY = 1'b1;
        @(negedge clk);
        check_val("ph_out_in_len", 128'(got_oi.size() - b_oi), 128'(exp_oi.size()));
        check_val("ph_out_inj_len", 128'(got_oj.size() - b_oj), 128'(exp_oj.size()));
        check_val("ph_log_len", 128'(got_lg.size() - b_lg), 128'(exp_lg.size()));
        for (int i = 0; i < exp_oi.size() && b_oi + i < got_oi.size(); i++)
            check_val("ph_out_in_beat", 128'(got_oi[b_oi + i]), 128'(exp_oi[i]));
        for (int i = 0; i < exp_oj.size() && b_oj + i < got_oj.size(); i++)
            check_val("ph_out_inj_beat", 128'(got_oj[b_oj + i]), 128'(exp_oj[i]));
        for (int i = 0; i < exp_lg.size() && b_lg + i < got_lg.size(); i++)
            check_val("ph_log_beat", 128'(got_lg[b_lg + i]), 128'(exp_lg[i]));
        check_val("ph_cnt_drop", 128'(cnt_drop_pkts), 128'(sat(e_drop)));
        check_val("ph_cnt_inj", 128'(cnt_inj_pkts), 128'(sat(e_inj)));
        check_val("ph_cnt_log", 128'(cnt_log_beats), 128'(sat(e_log)));
        check_val("ph_busy", 128'(busy), 128'(0));
        drop = 1'b0;
        log_en = 1'b0;
    endtask

    initial begin : main
        beat_t b0, b1, bi0, bi1;
        beat_t pk[5];
        int base_o, base_l;

        set_src(1'b0, mk_beat(1'b0, 1'b0), 1'b1);
        set_src(1'b1, mk_beat(1'b1, 1'b0), 1'b0);
        out_if.TREADY = 1'b1;
        log_if.TREADY = 1'b1;

        // Reset with input valid: everything quiet.
        repeat (3) @(negedge clk);
        check_val("rst_out_valid", 128'(out_if.TVALID), 128'(0));
        check_val("rst_log_valid", 128'(log_if.TVALID), 128'(0));
        check_val("rst_in_ready", 128'(in_if.TREADY), 128'(0));
        check_val("rst_inj_ready", 128'(inj_if.TREADY), 128'(0));
        check_val("rst_busy", 128'(busy), 128'(0));
        check_val("rst_cnts", 128'({cnt_drop_pkts, cnt_inj_pkts, cnt_log_beats}), 128'(0));
        in_if.TVALID = 1'b0;
        rstn = 1'b1;
        @(posedge clk); #1;

        run_phase(1, 0, 4, 1'b0, 1'b0, 1'b0);

        // Pause raised at beat 2 of a 5-beat packet.
        for (int k = 0; k < 5; k++) pk[k] = mk_beat(1'b0, k == 4);
        for (int k = 0; k < 5; k++) begin
            set_src(1'b0, pk[k], 1'b1);
            if (k == 2) pause = 1'b1;
            @(negedge clk);
            check_val("bpause_in_ready", 128'(in_if.TREADY), 128'(1));
            check_val("bpause_out_data", 128'(out_if.TDATA), 128'(pk[k][DW+KW+DSW+IW:KW+DSW+IW+1]));
            @(posedge clk); #1;
        end
        set_src(1'b0, mk_beat(1'b0, 1'b1), 1'b1);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check_val("bpause_stall_rdy", 128'(in_if.TREADY), 128'(0));
            check_val("bpause_stall_vld", 128'(out_if.TVALID), 128'(0));
            @(posedge clk); #1;
        end
        pause = 1'b0;
        @(negedge clk);
        check_val("bpause_release", 128'(in_if.TREADY), 128'(1));
        @(posedge clk); #1;
        in_if.TVALID = 1'b0;

        run_phase(3, 0, 4, 1'b1, 1'b1, 1'b0);

        // Fork back-pressure: log branch stalls three cycles.
        log_en = 1'b1;
        pulse_clr();
        base_o = got_oi.size();
        base_l = got_lg.size();
        b0 = mk_beat(1'b0, 1'b0);
        b1 = mk_beat(1'b0, 1'b1);
        log_if.TREADY = 1'b0;
        set_src(1'b0, b0, 1'b1);
        @(negedge clk);
        check_val("fbp_out_valid0", 128'(out_if.TVALID), 128'(1));
        check_val("fbp_in_ready0", 128'(in_if.TREADY), 128'(0));
        for (int c = 0; c < 2; c++) begin
            @(posedge clk); #1;
            @(negedge clk);
            check_val("fbp_out_held", 128'(out_if.TVALID), 128'(0));
            check_val("fbp_in_held", 128'(in_if.TREADY), 128'(0));
            check_val("fbp_log_valid", 128'(log_if.TVALID), 128'(1));
        end
        @(posedge clk); #1 log_if.TREADY = 1'b1;
        @(negedge clk);
        check_val("fbp_in_ready", 128'(in_if.TREADY), 128'(1));
        check_val("fbp_no_dup", 128'(out_if.TVALID), 128'(0));
        @(posedge clk); #1 set_src(1'b0, b1, 1'b1);
        @(negedge clk);
        check_val("fbp_beat1_rdy", 128'(in_if.TREADY), 128'(1));
        @(posedge clk); #1 in_if.TVALID = 1'b0;
        @(negedge clk);
        check_val("fbp_out_count", 128'(got_oi.size() - base_o), 128'(2));
        check_val("fbp_log_count", 128'(got_lg.size() - base_l), 128'(2));
        if (got_oi.size() > base_o) check_val("fbp_out_beat0", 128'(got_oi[base_o]), 128'(b0));
        check_val("fbp_cnt_log", 128'(cnt_log_beats), 128'(2));
        log_en = 1'b0;

        // Inject splice: both valid in IDLE, inject wins.
        pulse_clr();
        b0 = mk_beat(1'b0, 1'b0);
        b1 = mk_beat(1'b0, 1'b1);
        bi0 = mk_beat(1'b1, 1'b0);
        bi1 = mk_beat(1'b1, 1'b1);
        set_src(1'b0, b0, 1'b1);
        set_src(1'b1, bi0, 1'b1);
        @(negedge clk);
        check_val("inj_first_rdy", 128'(inj_if.TREADY), 128'(1));
        check_val("inj_first_in_blk", 128'(in_if.TREADY), 128'(0));
        check_val("inj_first_src", 128'(out_if.TID), 128'(bi0[IW:1]));
        @(posedge clk); #1 set_src(1'b1, bi1, 1'b1);
        @(negedge clk);
        check_val("inj_mid_in_blk", 128'(in_if.TREADY), 128'(0));
        check_val("inj_mid_busy", 128'(busy), 128'(1));
        check_val("inj_last_data", 128'(out_if.TDATA), 128'(bi1[DW+KW+DSW+IW:KW+DSW+IW+1]));
        @(posedge clk); #1 inj_if.TVALID = 1'b0;
        @(negedge clk);
        check_val("inj_then_in_rdy", 128'(in_if.TREADY), 128'(1));
        check_val("inj_then_in_src", 128'(out_if.TID), 128'(b0[IW:1]));
        check_val("inj_cnt", 128'(cnt_inj_pkts), 128'(1));
        @(posedge clk); #1 set_src(1'b0, b1, 1'b1);
        @(negedge clk);
        @(posedge clk); #1 in_if.TVALID = 1'b0;
        @(negedge clk);
        check_val("inj_end_busy", 128'(busy), 128'(0));

        // Counter saturation and clear priority.
        drop = 1'b1;
        pulse_clr();
        set_src(1'b0, mk_beat(1'b0, 1'b1), 1'b1);
        repeat (14) @(posedge clk);
        @(negedge clk);
        check_val("sat_drop14", 128'(cnt_drop_pkts), 128'(14));
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("sat_drop17", 128'(cnt_drop_pkts), 128'(CMAX));
        check_val("sat_log_zero", 128'(cnt_log_beats), 128'(0));
        clr_cnt = 1'b1;
        @(posedge clk); #1;
        clr_cnt = 1'b0;
        in_if.TVALID = 1'b0;
        @(negedge clk);
        check_val("sat_clr_wins", 128'(cnt_drop_pkts), 128'(0));
        drop = 1'b0;
        @(posedge clk); #1;

        for (int ph = 0; ph < 12; ph++)
            run_phase(int'($urandom_range(1, 4)), int'($urandom_range(0, 3)), 0,
                      1'($urandom), 1'($urandom), 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
